// File: rtl/spi_slave_reg_tx_pkg.sv
// spi_slave_reg_tx_pkg: shared types and constants for the SPI register read transmitter
package spi_slave_reg_tx_pkg;
  typedef enum logic [1:0] {IDLE, DUMMY, SHIFT} state_e;
  localparam int REG_ADDR_W = 2;
  localparam int BITS_PER_BEAT_SINGLE = 1;
  localparam int BITS_PER_BEAT_QUAD = 4;
  function automatic int beat_count(input int reg_size, input logic qpi);
    return qpi ? reg_size / BITS_PER_BEAT_QUAD : reg_size / BITS_PER_BEAT_SINGLE;
  endfunction
endpackage

// File: rtl/spi_slave_reg_tx_shift.sv
// spi_slave_reg_tx_shift: loadable MSB-first shift register with 1/4-bit shift and beat counter
module spi_slave_reg_tx_shift
  import spi_slave_reg_tx_pkg::*;
#(
  parameter int REG_SIZE = 8
) (
  input  logic                sclk,
  input  logic                rstn,
  input  logic                load_i,
  input  logic                shift_i,
  input  logic                qpi_i,
  input  logic [REG_SIZE-1:0] data_i,
  output logic [3:0]          top_o,
  output logic                last_o
);
  localparam int CW = $clog2(REG_SIZE);
  logic [REG_SIZE-1:0] sr_q, sr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = data_i;
      cnt_d = CW'(beat_count(REG_SIZE, qpi_i) - 1);
    end else if (shift_i) begin
      sr_d  = qpi_i ? sr_q << 4 : sr_q << 1;
      cnt_d = cnt_q - 1'b1;
    end
  end
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end
  assign top_o  = sr_q[REG_SIZE-1 -: 4];
  assign last_o = cnt_q == '0;
endmodule

// File: rtl/spi_slave_reg_tx.sv
// spi_slave_reg_tx: SPI slave config-register read transmitter (single/QPI, dummy cycles).
// Define SPI_REG_TX_STREAM_EN to let cont stream consecutive registers without a gap.
module spi_slave_reg_tx
  import spi_slave_reg_tx_pkg::*;
#(
  parameter int REG_SIZE = 8
) (
  input  logic                  sclk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic                  cancel,
  input  logic                  cont,
  input  logic                  en_qpi,
  input  logic [7:0]            dummy_cycles,
  output logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [REG_SIZE-1:0]   rd_data,
  output logic [3:0]            sdo,
  output logic [3:0]            sdo_oe,
  output logic                  busy,
  output logic                  done
);
`ifdef SPI_REG_TX_STREAM_EN
  localparam bit STREAM_EN = 1'b1;
`else
  localparam bit STREAM_EN = 1'b0;
`endif
  state_e                state_q, state_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic                  qpi_q, qpi_d;
  logic [7:0]            dcnt_q, dcnt_d;
  logic                  done_q, done_d;
  logic                  load, shift, last, stream;
  logic [3:0]            top;
  assign stream = STREAM_EN & cont & (state_q == SHIFT) & last;
  // While streaming, the register file must already present the next address on the load edge
  assign rd_addr = (state_q == IDLE) ? addr : stream ? addr_q + 1'b1 : addr_q;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    qpi_d   = qpi_q;
    dcnt_d  = dcnt_q;
    done_d  = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    if (cancel) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          addr_d  = addr;
          qpi_d   = en_qpi;
          load    = dummy_cycles == 8'd0;
          dcnt_d  = dummy_cycles - 8'd1;
          state_d = (dummy_cycles == 8'd0) ? SHIFT : DUMMY;
        end
        DUMMY: begin
          load    = dcnt_q == 8'd0;
          dcnt_d  = dcnt_q - 8'd1;
          state_d = (dcnt_q == 8'd0) ? SHIFT : DUMMY;
        end
        SHIFT: begin
          shift = 1'b1;
          if (last) begin
            load    = stream;
            addr_d  = stream ? addr_q + 1'b1 : addr_q;
            state_d = stream ? SHIFT : IDLE;
            done_d  = !stream;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      qpi_q   <= 1'b0;
      dcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      qpi_q   <= qpi_d;
      dcnt_q  <= dcnt_d;
      done_q  <= done_d;
    end
  end
  spi_slave_reg_tx_shift #(.REG_SIZE(REG_SIZE)) u_shift (
    .sclk   (sclk),
    .rstn   (rstn),
    .load_i (load),
    .shift_i(shift),
    .qpi_i  (qpi_d),
    .data_i (rd_data),
    .top_o  (top),
    .last_o (last)
  );
  assign sdo    = (state_q != SHIFT) ? 4'h0 : qpi_q ? top : {3'b000, top[3]};
  assign sdo_oe = (state_q != SHIFT) ? 4'h0 : qpi_q ? 4'hF : 4'h1;
  assign busy   = state_q != IDLE;
  assign done   = done_q;
endmodule

// File: tb/tb_spi_slave_reg_tx.sv
// tb_spi_slave_reg_tx: randomized self-checking bench against a per-cycle transfer model
module tb_spi_slave_reg_tx;
  localparam int RS = 8;
`ifdef SPI_REG_TX_STREAM_EN
  localparam bit STREAM = 1'b1;
`else
  localparam bit STREAM = 1'b0;
`endif
  logic          sclk = 1'b0;
  logic          rstn, start, cancel, cont, en_qpi;
  logic [1:0]    addr, rd_addr;
  logic [7:0]    dummy_cycles;
  logic [RS-1:0] rd_data;
  logic [3:0]    sdo, sdo_oe;
  logic          busy, done;
  logic [RS-1:0] regs [4];
  int            total = 0, bad = 0;

  always #5 sclk = ~sclk;
  assign rd_data = regs[rd_addr];

  spi_slave_reg_tx #(.REG_SIZE(RS)) dut (
    .sclk(sclk), .rstn(rstn), .start(start), .addr(addr), .cancel(cancel),
    .cont(cont), .en_qpi(en_qpi), .dummy_cycles(dummy_cycles), .rd_addr(rd_addr),
    .rd_data(rd_data), .sdo(sdo), .sdo_oe(sdo_oe), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Entered #1 after a posedge with the DUT idle; leaves it idle the same way.
  task automatic xfer(input logic [1:0] a, input bit q, input int n, input int cancel_at, input int nstream);
    int b, eff, last_j, r, bk;
    logic [RS-1:0] vals [4];
    logic [3:0] e_sdo;
    b = q ? RS / 4 : RS;
    eff = STREAM ? nstream : 1;
    last_j = n + eff * b;
    for (int i = 0; i < 4; i++) vals[i] = regs[(int'(a) + i) % 4];
    start = 1'b1; addr = a; en_qpi = q; dummy_cycles = 8'(n); cont = nstream > 1;
    for (int j = 0; j <= last_j; j++) begin
      @(posedge sclk); #1;
      if (cancel_at >= 0 && j == cancel_at + 1) begin
        chk("cancel_idle", {busy, done, sdo_oe}, 6'b0);
        cancel = 1'b0; start = 1'b0;
        return;
      end
      if (j == 0) chk("rd_addr_captured", rd_addr, a);
      if (j < n) begin
        chk("dummy_oe", {busy, done, sdo_oe, sdo}, {2'b10, 8'h00});
      end else if (j < last_j) begin
        r = (j - n) / b;
        bk = (j - n) % b;
        e_sdo = q ? 4'((vals[r] >> (RS - 4 - 4 * bk)) & 8'hF) : {3'b000, vals[r][RS-1-bk]};
        chk("beat_sdo", sdo, e_sdo);
        chk("beat_oe", sdo_oe, q ? 4'hF : 4'h1);
        chk("beat_busy_done", {busy, done}, 2'b10);
        // register writes after the load must not disturb bits in flight
        if ($urandom_range(0, 2) == 0) regs[(int'(a) + r) % 4] = RS'($urandom);
      end else begin
        chk("end_done", {busy, done, sdo_oe}, 6'b010000);
      end
      cancel = (j == cancel_at);
      cont = (j + 1) < n + nstream * b;
      if (j + 1 <= last_j - 1 || (cancel_at >= 0 && j < cancel_at)) begin
        start = 1'($urandom); addr = 2'($urandom); en_qpi = 1'($urandom);
        dummy_cycles = 8'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int n, q, b, ns, ca;
    rstn = 1'b0; start = 1'b0; cancel = 1'b0; cont = 1'b0; en_qpi = 1'b0;
    addr = 2'd0; dummy_cycles = 8'd0;
    for (int i = 0; i < 4; i++) regs[i] = RS'(i * 17);
    repeat (2) @(posedge sclk);
    #1;
    chk("reset_outputs", {busy, done, sdo_oe, sdo}, 10'h0);
    rstn = 1'b1;
    @(posedge sclk); #1;
    chk("idle_rd_addr", rd_addr, addr);
    regs[1] = 8'h20; xfer(2'd1, 1'b0, 0, -1, 1);
    regs[0] = 8'hA5; xfer(2'd0, 1'b1, 0, -1, 1);
    regs[2] = 8'h81; xfer(2'd2, 1'b0, 3, -1, 1);
    regs[3] = 8'h5C; xfer(2'd3, 1'b0, 0, 3, 1);
    regs[3] = 8'h3E; xfer(2'd3, 1'b0, 1, -1, 1);
    regs[3] = 8'hC7; regs[0] = 8'h1B; xfer(2'd3, 1'b1, 0, -1, 2);
    for (int t = 0; t < 40; t++) begin
      n = $urandom_range(0, 4);
      q = $urandom_range(0, 1);
      ns = $urandom_range(1, 4);
      b = q ? RS / 4 : RS;
      ca = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n + (STREAM ? ns : 1) * b - 1) : -1;
      for (int i = 0; i < 4; i++) regs[i] = RS'($urandom);
      xfer(2'($urandom), 1'(q), n, ca, ns);
    end
    start = 1'b1; addr = 2'd1; en_qpi = 1'b0; dummy_cycles = 8'd0;
    @(posedge sclk); #1;
    start = 1'b0;
    @(posedge sclk); #2;
    rstn = 1'b0;
    #1;
    chk("async_reset", {busy, done, sdo_oe, sdo}, 10'h0);
    @(posedge sclk); #1;
    rstn = 1'b1;
    regs[2] = 8'h96; xfer(2'd2, 1'b1, 2, -1, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
